// File: rtl/auto_blackbox0_tx.sv
// Two-symbol serializer: a 3-bit word plus pad bit leaves as two 2-bit symbols.
// Define AUTO_BLACKBOX0_TX_PARITY_EN to make the pad bit even parity over C.
module auto_blackbox0_tx #(
    parameter logic [1:0] IDLE_OUT = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic [2:0] C,
    output logic [1:0] OUT,
    output logic       COUT,
    output logic       BUSY
);
    typedef enum logic [1:0] {IDLE, S0, S1} state_t;

    state_t     state, state_nxt;
    logic [1:0] out_nxt;
    logic       cout_nxt;
    logic       c2_q, c2_nxt;
    logic       pad_q, pad_nxt;
    logic       pad_in;

`ifdef AUTO_BLACKBOX0_TX_PARITY_EN
    assign pad_in = C[2] ^ C[1] ^ C[0];
`else
    assign pad_in = 1'b0;
`endif

    assign BUSY = (state == S0);

    always_comb begin
        state_nxt = state;
        out_nxt   = OUT;
        cout_nxt  = COUT;
        c2_nxt    = c2_q;
        pad_nxt   = pad_q;
        if (B) begin
            case (state)
                S0: begin
                    out_nxt   = {pad_q, c2_q};
                    cout_nxt  = 1'b1;
                    state_nxt = S1;
                end
                IDLE, S1: begin
                    if (A) begin
                        out_nxt   = C[1:0];
                        cout_nxt  = 1'b1;
                        c2_nxt    = C[2];
                        pad_nxt   = pad_in;
                        state_nxt = S0;
                    end else begin
                        out_nxt   = IDLE_OUT;
                        cout_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    out_nxt   = IDLE_OUT;
                    cout_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            OUT   <= IDLE_OUT;
            COUT  <= 1'b0;
            c2_q  <= 1'b0;
            pad_q <= 1'b0;
        end else begin
            state <= state_nxt;
            OUT   <= out_nxt;
            COUT  <= cout_nxt;
            c2_q  <= c2_nxt;
            pad_q <= pad_nxt;
        end
    end
endmodule

// File: tb/tb_auto_blackbox0_tx.sv
// Scoreboard bench for auto_blackbox0_tx: directed words, stall, mid-word reset,
// and a second instance with IDLE_OUT=2'b11 for the idle value.
module tb_auto_blackbox0_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       A = 1'b0, B = 1'b0;
    logic [2:0] C = 3'b000;
    logic [1:0] out1, out2;
    logic       cout1, cout2, busy1, busy2;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic edge_en = 1'b0;
    logic [1:0] expq[$];

    auto_blackbox0_tx dut1 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C),
        .OUT(out1), .COUT(cout1), .BUSY(busy1)
    );
    auto_blackbox0_tx #(.IDLE_OUT(2'b11)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C),
        .OUT(out2), .COUT(cout2), .BUSY(busy2)
    );

    always #5 clk = ~clk;

    function automatic logic tb_pad(input logic [2:0] c);
`ifdef AUTO_BLACKBOX0_TX_PARITY_EN
        return c[2] ^ c[1] ^ c[0];
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic a, input logic b, input logic [2:0] c);
        A = a; B = b; C = c;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [2:0] c);
        expq.push_back(c[1:0]);
        expq.push_back({tb_pad(c), c[2]});
    endtask

    // Only an enabled, non-reset edge can present a fresh symbol.
    always @(posedge clk) edge_en <= rst_n && B;

    always @(negedge clk) begin
        if (rst_n && edge_en && cout1) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got OUT=%b COUT=1 expected no symbol", out1);
            end else begin
                logic [1:0] e;
                e = expq.pop_front();
                pops++;
                if (out1 !== e || cout2 !== 1'b1 || out2 !== e) begin
                    failures++;
                    $display("FAIL sb_symbol: got OUT=%b/%b expected %b", out1, out2, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_out", {2'b0, out1}, 4'h0);
        chk("rst_cout_busy", {2'b0, cout1, busy1}, 4'h0);
        chk("rst_out_idle11", {2'b0, out2}, 4'h3);

        // Single word, loaded on the first edge after release; C changes afterwards
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_word(3'b101);
        cyc(1, 1, 3'b101);
        chk("single_busy_s0", {3'b0, busy1}, 4'h1);
        cyc(0, 1, 3'b010);
        chk("single_busy_s1", {3'b0, busy1}, 4'h0);
        cyc(0, 1, 3'b000);
        chk("single_end_cout", {3'b0, cout1}, 4'h0);
        chk("single_end_out", {2'b0, out1}, 4'h0);
        chk("single_end_idle11", {2'b0, out2}, 4'h3);

        // Back-to-back words with A held high (A in S0 ignored)
        push_word(3'b010);
        cyc(1, 1, 3'b010);
        cyc(1, 1, 3'b111);
        chk("b2b_s1_busy", {3'b0, busy1}, 4'h0);
        push_word(3'b111);
        cyc(1, 1, 3'b111);
        chk("b2b_reload_busy", {2'b0, cout1, busy1}, 4'h3);
        cyc(0, 1, 3'b000);
        cyc(0, 1, 3'b000);
        chk("b2b_end_cout", {3'b0, cout1}, 4'h0);

        // Stall in S0 for three cycles
        push_word(3'b011);
        cyc(1, 1, 3'b011);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 3'(i + 4));
            chk("stall_out", {2'b0, out1}, 4'h3);
            chk("stall_cout_busy", {2'b0, cout1, busy1}, 4'h3);
        end
        cyc(0, 1, 3'b000);
        chk("stall_resume_out", {2'b0, out1}, {2'b0, tb_pad(3'b011), 1'b0});
        cyc(0, 1, 3'b000);
        chk("stall_end_cout", {3'b0, cout1}, 4'h0);

        // Mid-word reset during S1, asserted between edges
        push_word(3'b110);
        cyc(1, 1, 3'b110);
        cyc(0, 1, 3'b000);
        #6;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {2'b0, out1}, 4'h0);
        chk("midrst_cout_busy", {2'b0, cout1, busy1}, 4'h0);
        chk("midrst_idle11", {2'b0, out2}, 4'h3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 3'b000);
            chk("postrst_cout", {3'b0, cout1}, 4'h0);
            chk("postrst_idle11", {2'b0, out2}, 4'h3);
        end

        // Everything expected was seen
        chk("sb_drained", (expq.size() == 0) ? 4'h0 : 4'h1, 4'h0);
        chk("sb_pops", 4'(pops), 4'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/auto_blackbox0_tx.md
AUTO_BLACKBOX0_TX -- requirements
Module: auto_blackbox0_tx

Interface
REQ-001 The block SHALL have parameter IDLE_OUT, default 2'b00, giving the OUT value driven while no symbol is valid.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port A, input, 1 bit: load strobe requesting capture of C.
REQ-005 The block SHALL have port B, input, 1 bit: enable; when 0, all state and outputs hold.
REQ-006 The block SHALL have port C, input, 3 bits: data word to transmit.
REQ-007 The block SHALL have port OUT, output, 2 bits, registered: the transmitted symbol.
REQ-008 The block SHALL have port COUT, output, 1 bit, registered: OUT holds a valid symbol.
REQ-009 The block SHALL have port BUSY, output, 1 bit, combinational from state: a new load would be ignored this cycle.

Function
REQ-010 The FSM SHALL have three states: IDLE (no symbol), S0 (symbol 0 on OUT), S1 (symbol 1 on OUT).
REQ-011 The load condition SHALL be B=1 and A=1 with state IDLE or S1.
REQ-012 On a load edge, the block SHALL set OUT<=C[1:0] and COUT<=1, capture C[2] and the pad bit, and go to S0.
REQ-013 In S0 with B=1, the block SHALL set OUT<={pad,C[2]} from the captured values, keep COUT=1, and go to S1; A SHALL be ignored.
REQ-014 In S1 with B=1 and A=0, the block SHALL set OUT<=IDLE_OUT and COUT<=0, and go to IDLE.
REQ-015 In S1 with B=1 and A=1, a load SHALL occur per REQ-012, giving back-to-back words with COUT continuously 1.
REQ-016 In IDLE with B=1 and A=0, the block SHALL keep OUT=IDLE_OUT and COUT=0.
REQ-017 With B=0 in any state, state, OUT, COUT and captured data SHALL hold; A and C SHALL be ignored.
REQ-018 Latency SHALL be: symbol 0 valid in the cycle after the load edge, symbol 1 one enabled cycle later; each word occupies exactly two enabled COUT=1 cycles.
REQ-019 BUSY SHALL be 1 only in state S0.
REQ-020 C SHALL be sampled only on the load edge; changes at other times SHALL NOT affect OUT.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, OUT=IDLE_OUT, COUT=0, and captured data=0, regardless of clk.
REQ-022 Reset asserted mid-word (S0 or S1) SHALL abort the word; no symbol of it SHALL appear after release.
REQ-023 The first edge with rst_n=1 SHALL be able to perform a load.

Configuration
REQ-024 Macro AUTO_BLACKBOX0_TX_PARITY_EN SHALL select the pad bit.
REQ-025 With the macro defined, pad SHALL be C[2]^C[1]^C[0] sampled at load (even parity over the four transmitted data-plus-pad bits).
REQ-026 Without the macro, pad SHALL be constant 0, and no parity logic SHALL be synthesized.

Verification
REQ-027 Reset: rst_n=0 asserted between clock edges -> OUT=2'b00, COUT=0, BUSY=0 immediately.
REQ-028 Single word: C=3'b101, A=1 for one cycle with B=1 -> OUT=2'b01 then OUT={pad,1} with COUT=1, then COUT=0; pad=0 without the macro, pad=0 with the macro.
REQ-029 Back-to-back words: C=3'b010 then C=3'b111, with A held high -> OUT sequence 10, {p,0}, 11, {p,1} with COUT=1 for 4 consecutive cycles; the A in S0 is ignored; p=1/1 with the macro.
REQ-030 Stall: B=0 for 3 cycles while in S0 -> OUT and COUT frozen, BUSY=1; OUT proceeds to symbol 1 on the first edge with B=1.
REQ-031 Mid-word reset: rst_n pulsed low during S1 -> OUT=IDLE_OUT, COUT=0; no residual symbol after release.
REQ-032 Parameter: IDLE_OUT=2'b11 -> OUT=2'b11 in IDLE after reset and after the last word completes.
